// File: rtl/hazard_ctrl_if.sv
// D-stage hazard request (addresses, Tuse/Tnew) and the stall/forward response.
interface hazard_ctrl_if;
   logic [4:0] d_raddr0;
   logic [4:0] d_raddr1;
   logic [2:0] d_tuse0;
   logic [2:0] d_tuse1;
   logic [4:0] d_waddr;
   logic [2:0] d_tnew;
   logic       stall;
   logic [1:0] fwd_d0;
   logic [1:0] fwd_d1;
   logic [1:0] fwd_e0;
   logic [1:0] fwd_e1;
   logic [1:0] fwd_m1;

   modport master (
      output d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
      input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
   );

   modport slave (
      input  d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
      output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage pipeline: tracks dest/Tnew through
// E/M/W and resolves D, E and M operand hazards combinationally.
module hazard_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter logic [2:0]  TUSE_NONE = 3'd7
) (
   input  logic             clk,
   input  logic             reset_n,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [4:0] raddr0;
      logic [4:0] raddr1;
      logic [4:0] waddr;
      logic [2:0] tnew;
   } stage_t;

   stage_t e_q, m_q, w_q;

   logic       stall;
   logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1;

   function automatic logic match(stage_t s, logic [4:0] r);
      return (r != 5'd0) && (s.waddr == r);
   endfunction

   function automatic stage_t age(stage_t s);
      stage_t a;
      a = s;
      a.tnew = (s.tnew == 3'd0) ? 3'd0 : s.tnew - 3'd1;
      return a;
   endfunction

   function automatic logic opnd_stall(logic [4:0] r, logic [2:0] tuse,
                                       stage_t e, stage_t m);
      if (tuse == TUSE_NONE) return 1'b0;
      return (match(e, r) && (e.tnew > tuse)) || (match(m, r) && (m.tnew > tuse));
   endfunction

   // Youngest match wins; a not-yet-ready youngest producer forwards nothing
   // (older stages hold stale data for that register).
   function automatic logic [1:0] sel_d(logic [4:0] r, logic [2:0] tuse,
                                        stage_t e, stage_t m, stage_t w);
      if (tuse == TUSE_NONE) return 2'd0;
      if (match(e, r)) return (e.tnew == 3'd0) ? 2'd1 : 2'd0;
      if (match(m, r)) return (m.tnew == 3'd0) ? 2'd2 : 2'd0;
      if (match(w, r)) return (w.tnew == 3'd0) ? 2'd3 : 2'd0;
      return 2'd0;
   endfunction

   function automatic logic [1:0] sel_e(logic [4:0] r, stage_t m, stage_t w);
      if (match(m, r)) return (m.tnew == 3'd0) ? 2'd2 : 2'd0;
      if (match(w, r)) return (w.tnew == 3'd0) ? 2'd3 : 2'd0;
      return 2'd0;
   endfunction

   always_comb begin
      stall  = opnd_stall(hz.d_raddr0, hz.d_tuse0, e_q, m_q)
             | opnd_stall(hz.d_raddr1, hz.d_tuse1, e_q, m_q);
      fwd_d0 = sel_d(hz.d_raddr0, hz.d_tuse0, e_q, m_q, w_q);
      fwd_d1 = sel_d(hz.d_raddr1, hz.d_tuse1, e_q, m_q, w_q);
      fwd_e0 = sel_e(e_q.raddr0, m_q, w_q);
      fwd_e1 = sel_e(e_q.raddr1, m_q, w_q);
      fwd_m1 = match(w_q, m_q.raddr1) ? 2'd3 : 2'd0;
   end

   assign hz.stall  = stall;
   assign hz.fwd_d0 = fwd_d0;
   assign hz.fwd_d1 = fwd_d1;
   assign hz.fwd_e0 = fwd_e0;
   assign hz.fwd_e1 = fwd_e1;
   assign hz.fwd_m1 = fwd_m1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q       <= '0;
         m_q       <= '0;
         w_q       <= '0;
         stall_cnt <= '0;
      end else begin
         m_q <= age(e_q);
         w_q <= age(m_q);
         e_q <= stall ? '0 : stage_t'{hz.d_raddr0, hz.d_raddr1, hz.d_waddr, hz.d_tnew};
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table through a scoreboard queue, plus
// hand-driven reset/stall-count sequences.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset_n;
   logic [1:0] stall_cnt;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.CNT_W(2), .TUSE_NONE(3'd7)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .hz        (hif.slave),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] r0, r1, wa;
      logic [2:0] t0, t1, tn;
      logic       st;
      logic [1:0] fd0, fd1, fe0, fe1, fm1;
   } vec_t;

   typedef struct {
      logic       st;
      logic [1:0] fd0, fd1, fe0, fe1, fm1, cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(int r0, int r1, int t0, int t1, int wa, int tn,
                               int st, int fd0, int fd1, int fe0, int fe1, int fm1);
      vec_t v;
      v.r0 = 5'(r0); v.r1 = 5'(r1); v.t0 = 3'(t0); v.t1 = 3'(t1);
      v.wa = 5'(wa); v.tn = 3'(tn); v.st = 1'(st);
      v.fd0 = 2'(fd0); v.fd1 = 2'(fd1); v.fe0 = 2'(fe0); v.fe1 = 2'(fe1); v.fm1 = 2'(fm1);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drv(input int r0, input int r1, input int t0, input int t1,
                      input int wa, input int tn);
      @(negedge clk);
      hif.d_raddr0 = 5'(r0); hif.d_raddr1 = 5'(r1);
      hif.d_tuse0  = 3'(t0); hif.d_tuse1  = 3'(t1);
      hif.d_waddr  = 5'(wa); hif.d_tnew   = 3'(tn);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      hif.d_raddr0 = '0; hif.d_raddr1 = '0; hif.d_tuse0 = 3'd7; hif.d_tuse1 = 3'd7;
      hif.d_waddr = '0; hif.d_tnew = '0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   int unsigned mcnt;

   initial begin
      reset_n = 1'b0;
      hif.d_raddr0 = '0; hif.d_raddr1 = '0; hif.d_tuse0 = 3'd7; hif.d_tuse1 = 3'd7;
      hif.d_waddr = '0; hif.d_tnew = '0;
      #12;
      chk("rst.stall", hif.stall, 0);
      chk("rst.fwd", {hif.fwd_d0, hif.fwd_d1, hif.fwd_e0, hif.fwd_e1, hif.fwd_m1}, 0);
      chk("rst.cnt", stall_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;

      //            r0  r1 t0 t1 wa tn  st d0 d1 e0 e1 m1
      vecs.push_back(mk( 0, 0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 0)); // lw $1
      vecs.push_back(mk( 1, 3, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0)); // addu $2,$1,$3
      vecs.push_back(mk( 1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 3, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 1, 7, 8, 2, 0, 0, 0, 0, 0, 0)); // lw $8
      vecs.push_back(mk( 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // beq $8,$0
      vecs.push_back(mk( 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 8, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      vecs.push_back(mk(10,11, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0)); // addu $5
      vecs.push_back(mk( 4, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // sw $5,0($4)
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 2, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 3));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0)); // lui $7
      vecs.push_back(mk( 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // beq $7,$0
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk( 0, 0, 1, 7, 0, 2, 0, 0, 0, 0, 0, 0)); // lw $0
      vecs.push_back(mk( 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0)); // addu $9,$0,$0
      vecs.push_back(mk( 0, 0, 7, 7,31, 0, 0, 0, 0, 0, 0, 0)); // jal
      vecs.push_back(mk(31,31, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0)); // unused reads of $31
      vecs.push_back(mk( 0, 0, 1, 7,12, 2, 0, 0, 0, 2, 2, 0)); // lw $12
      vecs.push_back(mk(12,12, 7, 7, 0, 0, 0, 0, 0, 0, 0, 3)); // unused reads of $12
      vecs.push_back(mk( 0, 0, 7, 7,14, 0, 0, 0, 0, 0, 0, 0)); // lui $14
      vecs.push_back(mk(14,14, 1, 1, 0, 0, 0, 1, 1, 0, 0, 3));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 2, 2, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 3));
      vecs.push_back(mk( 0, 0, 1, 1,16, 1, 0, 0, 0, 0, 0, 0)); // addu $16
      vecs.push_back(mk( 0, 0, 7, 7,16, 0, 0, 0, 0, 0, 0, 0)); // lui $16
      vecs.push_back(mk(16, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0)); // youngest producer wins
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mk( 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));

      mcnt = 0;
      foreach (vecs[i]) begin
         exp_t x;
         drv(vecs[i].r0, vecs[i].r1, vecs[i].t0, vecs[i].t1, vecs[i].wa, vecs[i].tn);
         x.st = vecs[i].st; x.fd0 = vecs[i].fd0; x.fd1 = vecs[i].fd1;
         x.fe0 = vecs[i].fe0; x.fe1 = vecs[i].fe1; x.fm1 = vecs[i].fm1;
         x.cnt = 2'(mcnt);
         sbq.push_back(x);
         if (x.st && mcnt < 3) mcnt++;
         #2;
         if (sbq.size() == 0) begin
            chk($sformatf("v%0d.queue", i), 0, 1);
         end else begin
            x = sbq.pop_front();
            chk($sformatf("v%0d.stall", i),  hif.stall,  x.st);
            chk($sformatf("v%0d.fwd_d0", i), hif.fwd_d0, x.fd0);
            chk($sformatf("v%0d.fwd_d1", i), hif.fwd_d1, x.fd1);
            chk($sformatf("v%0d.fwd_e0", i), hif.fwd_e0, x.fe0);
            chk($sformatf("v%0d.fwd_e1", i), hif.fwd_e1, x.fe1);
            chk($sformatf("v%0d.fwd_m1", i), hif.fwd_m1, x.fm1);
            chk($sformatf("v%0d.cnt", i),    stall_cnt,  x.cnt);
         end
      end

      // lw -> beq from a fresh reset: two stalls, then W forward
      do_reset();
      drv(0, 0, 1, 7, 1, 2);
      for (int k = 0; k < 2; k++) begin
         drv(1, 0, 0, 0, 0, 0);
         #2 chk($sformatf("lwbeq.stall%0d", k), hif.stall, 1);
      end
      drv(1, 0, 0, 0, 0, 0);
      #2;
      chk("lwbeq.stall_end", hif.stall, 0);
      chk("lwbeq.fwd_d0", hif.fwd_d0, 3);
      chk("lwbeq.cnt", stall_cnt, 2);

      // asynchronous reset in the middle of a stall
      do_reset();
      drv(0, 0, 1, 7, 1, 2);
      drv(1, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      #2;
      chk("arst.pre_stall", hif.stall, 1);
      chk("arst.pre_cnt", stall_cnt, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst.stall", hif.stall, 0);
      chk("arst.cnt", stall_cnt, 0);
      hif.d_raddr0 = '0; hif.d_tuse0 = 3'd7; hif.d_tuse1 = 3'd7;
      @(negedge clk);
      reset_n = 1'b1;

      // saturation: 5 stall cycles on a 2-bit counter
      do_reset();
      for (int p = 0; p < 2; p++) begin
         drv(0, 0, 1, 7, 1, 2);
         drv(1, 0, 0, 0, 0, 0);
         drv(1, 0, 0, 0, 0, 0);
         drv(1, 0, 0, 0, 0, 0);
         #2 chk($sformatf("sat.cnt_pair%0d", p), stall_cnt, (p == 0) ? 2 : 3);
      end
      drv(0, 0, 1, 7, 1, 2);
      drv(1, 3, 1, 1, 2, 1);
      #2 chk("sat.addu_stall", hif.stall, 1);
      drv(1, 3, 1, 1, 2, 1);
      #2;
      chk("sat.addu_nostall", hif.stall, 0);
      chk("sat.cnt", stall_cnt, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
